uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_transmitter.sv | 120 ++++++++++++
 tb/tb_uart_transmitter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud-select codes and the
// bit-period divisor used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] BAUD_4800   = 2'b00;
    localparam logic [1:0] BAUD_9600   = 2'b01;
    localparam logic [1:0] BAUD_19200  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    function automatic int unsigned uart_baud(input logic [1:0] s);
        case (s)
            BAUD_4800:  return 4800;
            BAUD_9600:  return 9600;
            BAUD_19200: return 19200;
            default:    return 115200;
        endcase
    endfunction

    // Rounded clocks-per-bit; 64-bit intermediate keeps the +baud/2 from overflowing.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input logic [1:0] s);
        longint unsigned b;
        longint unsigned q;
        b = longint'(uart_baud(s));
        q = (longint'(clk_hz) + b / 2) / b;
        return q[31:0];
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake and serial line of the UART transmitter.
interface uart_transmitter_if;

    logic [1:0] S;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_out;
    logic       a;

    modport master (
        output S, tx_data, tx_valid,
        input  tx_ready, serial_out, a
    );

    modport slave (
        input  S, tx_data, tx_valid,
        output tx_ready, serial_out, a
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick_o is high in the last clock of every div_i-clock period.
module uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] div_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i - W'(1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with selectable baud rate and a frame-done pulse.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DIV_OVERRIDE = 0
) (
    input  logic              clk_in,
    input  logic              reset,
    uart_transmitter_if.slave bus
);

    localparam int unsigned DIV_MAX = (DIV_OVERRIDE != 0) ? DIV_OVERRIDE
                                                          : uart_div(CLK_HZ, BAUD_4800);
    localparam int DIVW = $clog2(DIV_MAX + 1);

    uart_state_e     state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [DIVW-1:0] div_q, div_d, div_sel;
    logic [2:0]      idx_q, idx_d;
    logic            ser_q, ser_d;
    logic            rdy_en_q;
    logic            tick, ready, done, start_xfer;

    // Divisors fold to constants; no runtime division is built.
    always_comb begin
        div_sel = DIVW'(DIV_OVERRIDE);
        if (DIV_OVERRIDE == 0) begin
            case (bus.S)
                BAUD_4800:  div_sel = DIVW'(uart_div(CLK_HZ, BAUD_4800));
                BAUD_9600:  div_sel = DIVW'(uart_div(CLK_HZ, BAUD_9600));
                BAUD_19200: div_sel = DIVW'(uart_div(CLK_HZ, BAUD_19200));
                default:    div_sel = DIVW'(uart_div(CLK_HZ, BAUD_115200));
            endcase
        end
    end

    assign start_xfer = bus.tx_valid && ready;

    uart_baud_tick #(.W(DIVW)) u_tick (
        .clk_i  (clk_in),
        .rst_ni (reset),
        .clr_i  (state_q == IDLE),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            div_q    <= '0;
            idx_q    <= '0;
            ser_q    <= 1'b1;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            ser_q    <= ser_d;
            rdy_en_q <= 1'b1;
        end
    end

    // The line level is computed here and registered so serial_out never glitches.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        div_d   = div_q;
        idx_d   = idx_q;
        ser_d   = ser_q;
        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (start_xfer) begin
                    state_d = START;
                    data_d  = bus.tx_data;
                    div_d   = div_sel;
                    ser_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    ser_d   = data_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        ser_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        ser_d = data_q[idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                ser_d = 1'b1;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE) && rdy_en_q;
        done  = (state_q == STOP) && tick;
    end

    assign bus.tx_ready   = ready;
    assign bus.a          = done;
    assign bus.serial_out = ser_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: sent bytes are queued, a line monitor decodes frames and checks shape/timing.
module tb_uart_transmitter;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    always #5 clk = ~clk;

    uart_transmitter_if bus ();
    uart_transmitter_if bus2 ();

    uart_transmitter #(.CLK_HZ(100_000_000), .DIV_OVERRIDE(DIV)) dut (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    uart_transmitter #(.CLK_HZ(100_000_000), .DIV_OVERRIDE(0)) dut2 (
        .clk_in (clk),
        .reset  (rst2_n),
        .bus    (bus2)
    );

    typedef struct {
        logic [7:0] data;
        bit         shape_ok;
        int         a_pos;
        int         a_num;
        longint     start;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    int         n_pass   = 0;
    int         n_checks = 0;
    int         a_total  = 0;
    bit         in_frame = 0;
    longint     cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples every clock of a frame, decodes mid-window bits.
    initial begin
        logic   smp [FRAME];
        int     pos;
        frame_t cur;
        pos = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                in_frame = 0;
            end else begin
                if (bus.a === 1'b1) a_total++;
                if (!in_frame && bus.serial_out === 1'b0) begin
                    in_frame  = 1;
                    pos       = 0;
                    cur.start = cyc;
                    cur.a_num = 0;
                    cur.a_pos = -1;
                end
                if (in_frame) begin
                    smp[pos] = bus.serial_out;
                    if (bus.a === 1'b1) begin
                        cur.a_num++;
                        cur.a_pos = pos;
                    end
                    pos++;
                    if (pos == FRAME) begin
                        cur.shape_ok = (smp[0] === 1'b0) && (smp[9*DIV] === 1'b1);
                        for (int w = 0; w < 10; w++)
                            for (int k = 0; k < DIV; k++)
                                if (smp[w*DIV+k] !== smp[w*DIV]) cur.shape_ok = 0;
                        for (int i = 0; i < 8; i++) cur.data[i] = smp[(i+1)*DIV];
                        rx_q.push_back(cur);
                        in_frame = 0;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic xfer(input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && n < 4*FRAME) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.tx_ready !== 1'b1)
            $display("FAIL xfer_ready byte=%02h got ready=%b want 1", d, bus.tx_ready);
        else begin
            n_pass++;
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    task automatic get_frame(output frame_t f, output bit got);
        int n;
        n   = 0;
        got = 0;
        while (rx_q.size() == 0 && n < 4*FRAME) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() != 0) begin
            f   = rx_q.pop_front();
            got = 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.serial_out !== 1'b1) $display("FAIL rst_serial got %b want 1", bus.serial_out);
        else n_pass++;
        n_checks++;
        if (bus.tx_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", bus.tx_ready);
        else n_pass++;
        n_checks++;
        if (bus.a !== 1'b0) $display("FAIL rst_a got %b want 0", bus.a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", bus.tx_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        frame_t     f;
        bit         got;
        logic [7:0] e;
        int         a0;
        a0 = a_total;
        xfer(8'h50, 0);
        get_frame(f, got);
        n_checks++;
        if (!got) $display("FAIL single_frame got none want 1 frame");
        else begin
            n_pass++;
            e = pop_exp();
            n_checks++;
            if (f.data !== e) $display("FAIL single_data got %02h want %02h", f.data, e);
            else n_pass++;
            n_checks++;
            if (f.shape_ok !== 1'b1) $display("FAIL single_shape got %b want 1", f.shape_ok);
            else n_pass++;
            n_checks++;
            if (f.a_pos != FRAME-1 || f.a_num != 1)
                $display("FAIL single_a got pos=%0d num=%0d want pos=%0d num=1", f.a_pos, f.a_num, FRAME-1);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.tx_ready !== 1'b1 || bus.serial_out !== 1'b1)
            $display("FAIL single_idle got ready=%b line=%b want 1 1", bus.tx_ready, bus.serial_out);
        else n_pass++;
        n_checks++;
        if (a_total - a0 != 1) $display("FAIL single_a_count got %0d want 1", a_total - a0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        frame_t     f1, f2;
        bit         g1, g2;
        logic [7:0] e;
        xfer(8'hA5, 1);
        xfer(8'h3C, 0);
        get_frame(f1, g1);
        get_frame(f2, g2);
        n_checks++;
        if (!(g1 && g2)) $display("FAIL b2b_frames got %0d want 2", int'(g1) + int'(g2));
        else begin
            n_pass++;
            e = pop_exp();
            n_checks++;
            if (f1.data !== e || !f1.shape_ok) $display("FAIL b2b_first got %02h/%b want %02h/1", f1.data, f1.shape_ok, e);
            else n_pass++;
            e = pop_exp();
            n_checks++;
            if (f2.data !== e || !f2.shape_ok) $display("FAIL b2b_second got %02h/%b want %02h/1", f2.data, f2.shape_ok, e);
            else n_pass++;
            n_checks++;
            if (f2.start - f1.start != FRAME + 1)
                $display("FAIL b2b_gap got %0d want %0d", f2.start - f1.start, FRAME + 1);
            else n_pass++;
        end
    endtask

    task automatic test_midframe_change();
        frame_t     f;
        bit         got;
        logic [7:0] e;
        int         a0;
        a0 = a_total;
        xfer(8'h96, 0);
        repeat (40) @(negedge clk);
        bus.S        = 2'b11;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        get_frame(f, got);
        n_checks++;
        if (!got) $display("FAIL mid_frame got none want 1 frame");
        else begin
            n_pass++;
            e = pop_exp();
            n_checks++;
            if (f.data !== e || !f.shape_ok) $display("FAIL mid_data got %02h/%b want %02h/1", f.data, f.shape_ok, e);
            else n_pass++;
        end
        repeat (2*FRAME) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0 || in_frame) $display("FAIL mid_no_extra got frames=%0d busy=%b want 0 0", rx_q.size(), in_frame);
        else n_pass++;
        n_checks++;
        if (a_total - a0 != 1) $display("FAIL mid_a_count got %0d want 1", a_total - a0);
        else n_pass++;
        bus.S = 2'b00;
    endtask

    task automatic test_reset_midframe();
        frame_t     f;
        bit         got;
        logic [7:0] e;
        int         a0;
        a0 = a_total;
        xfer(8'h00, 0);
        repeat (69) @(posedge clk);
        #2;
        n_checks++;
        if (bus.serial_out !== 1'b0) $display("FAIL rmid_pre got %b want 0", bus.serial_out);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.serial_out !== 1'b1) $display("FAIL rmid_serial got %b want 1", bus.serial_out);
        else n_pass++;
        n_checks++;
        if (bus.tx_ready !== 1'b0 || bus.a !== 1'b0) $display("FAIL rmid_ready_a got %b %b want 0 0", bus.tx_ready, bus.a);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0 || a_total != a0) $display("FAIL rmid_abort got frames=%0d a=%0d want 0 0", rx_q.size(), a_total - a0);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_ready !== 1'b1) $display("FAIL rmid_ready_after got %b want 1", bus.tx_ready);
        else n_pass++;
        xfer(8'hFF, 0);
        get_frame(f, got);
        n_checks++;
        if (!got) $display("FAIL rmid_frame got none want 1 frame");
        else begin
            n_pass++;
            e = pop_exp();
            n_checks++;
            if (f.data !== e || !f.shape_ok || f.a_pos != FRAME-1)
                $display("FAIL rmid_data got %02h/%b/%0d want %02h/1/%0d", f.data, f.shape_ok, f.a_pos, e, FRAME-1);
            else n_pass++;
        end
    endtask

    task automatic test_real_baud();
        int n_lo, n_hi;
        n_lo = 0;
        n_hi = 0;
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        bus2.tx_data  = 8'h55;
        bus2.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus2.tx_valid = 1'b0;
        @(negedge clk);
        while (bus2.serial_out === 1'b0 && n_lo < 12000) begin
            n_lo++;
            @(negedge clk);
        end
        while (bus2.serial_out === 1'b1 && n_hi < 12000) begin
            n_hi++;
            @(negedge clk);
        end
        n_checks++;
        if (n_lo != 10417) $display("FAIL baud9600_start got %0d want 10417", n_lo);
        else n_pass++;
        n_checks++;
        if (n_hi != 10417) $display("FAIL baud9600_bit0 got %0d want 10417", n_hi);
        else n_pass++;
        rst2_n = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        rst2_n        = 1'b0;
        bus.S         = 2'b00;
        bus.tx_data   = 8'h00;
        bus.tx_valid  = 1'b0;
        bus2.S        = 2'b01;
        bus2.tx_data  = 8'h00;
        bus2.tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_midframe_change();
        test_reset_midframe();
        test_real_baud();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
